// File: rtl/ps2_code_display_ctrl.sv
// rtl/ps2_code_display_ctrl.sv - PS/2 Set-2 scan-code assembler for a 4-digit hex display.
// Optional prefix timeout enabled by defining SCAN_TIMEOUT_EN.
module ps2_code_display_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_err,
    output logic [15:0] code,
    output logic        code_valid,
    output logic        ext,
    output logic        brk,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    state_t      state_q, state_d;
    logic [15:0] code_q, code_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        code_valid_q;
    logic        err_q;
    logic        busy_q;

    logic        publish;
    logic [15:0] pub_code;
    logic        pub_ext;
    logic        pub_brk;
    logic        err_now;
    logic        timeout;
    logic        is_e0;
    logic        is_f0;

    assign is_e0 = (in_data == BYTE_E0);
    assign is_f0 = (in_data == BYTE_F0);

`ifdef SCAN_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] tcnt_q, tcnt_d;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        tcnt_d  = tcnt_q;
        timeout = 1'b0;
        if (in_valid || in_err || state_q == IDLE) begin
            tcnt_d = '0;
        end else if (tcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            code_q       <= 16'h0000;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            code_valid_q <= publish;
            err_q        <= err_now;
            busy_q       <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_err) begin
            state_d = IDLE;
        end else if (in_valid) begin
            if (is_e0) begin
                state_d = GOT_E0;
            end else if (is_f0) begin
                state_d = (state_q == GOT_E0) ? GOT_E0F0 : GOT_F0;
            end else begin
                state_d = IDLE;
            end
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    // in_err masks the byte; a repeated E0 inside GOT_E0 is tolerated.
    always_comb begin
        publish  = 1'b0;
        pub_code = 16'h0000;
        pub_ext  = 1'b0;
        pub_brk  = 1'b0;
        err_now  = 1'b0;
        if (in_err) begin
            err_now = 1'b1;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_e0 && !is_f0) begin
                        publish  = 1'b1;
                        pub_code = {8'h00, in_data};
                    end
                end
                GOT_E0: begin
                    if (!is_e0 && !is_f0) begin
                        publish  = 1'b1;
                        pub_code = {8'hE0, in_data};
                        pub_ext  = 1'b1;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    if (is_e0 || is_f0) begin
                        err_now = 1'b1;
                    end else begin
                        publish  = 1'b1;
                        pub_code = {8'hF0, in_data};
                        pub_ext  = (state_q == GOT_E0F0);
                        pub_brk  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            err_now = 1'b1;
        end
        code_d = publish ? pub_code : code_q;
        ext_d  = publish ? pub_ext  : ext_q;
        brk_d  = publish ? pub_brk  : brk_q;
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign ext        = ext_q;
    assign brk        = brk_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule
